// File: rtl/id_decode_queue.sv
// Instruction queue feeding a registered MIPS main-decode stage; one instruction per cycle.
// Latency: 1 cycle from push to out_valid when empty. Backpressure: in_ready drops when queue is full.
module id_decode_queue #(
  parameter int DEPTH     = 4,
  parameter int PC_W      = 32,
  parameter bit EN_MULDIV = 1'b1,
  parameter bit EN_CP0    = 1'b1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_inst,
  input  logic [PC_W-1:0]          in_pc,
  input  logic                     in_ds,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_inst,
  output logic [PC_W-1:0]          out_pc,
  output logic                     out_ds,
  output logic [19:0]              out_ctrl,
  output logic                     out_eret,
  output logic [4:0]               out_exc,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [31:0]   ERET_W = 32'h4200_0018;

  localparam logic [19:0] C_RW = 20'h80000, C_RD = 20'h40000, C_AS = 20'h20000;
  localparam logic [19:0] C_RET_CP0 = 20'h10000, C_RET_HILO = 20'h08000;
  localparam logic [19:0] C_MW = 20'h04000, C_MR = 20'h02000, C_HW = 20'h01000;
  localparam logic [19:0] C_HTR = 20'h00800, C_HS = 20'h00400;
  localparam logic [19:0] C_BR_Z = 20'h00200, C_BR_EQ = 20'h00100;
  localparam logic [19:0] C_J = 20'h00080, C_JS = 20'h00040, C_LNK = 20'h00020, C_LD = 20'h00010;
  localparam logic [19:0] C_BRK = 20'h00008, C_SYS = 20'h00004, C_RSV = 20'h00002, C_CPW = 20'h00001;

  logic [31:0]     inst_mem [DEPTH];
  logic [PC_W-1:0] pc_mem   [DEPTH];
  logic            ds_mem   [DEPTH];

  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            out_valid_q, out_ds_q, out_eret_q;
  logic [31:0]     out_inst_q;
  logic [PC_W-1:0] out_pc_q;
  logic [19:0]     out_ctrl_q;
  logic [4:0]      out_exc_q;

  logic            push, pop, rsv, is_eret;
  logic [31:0]     head;
  logic [19:0]     ctrl;
  logic [4:0]      exc;

  assign in_ready = (count_q != FULL);
  assign push     = in_valid && in_ready;
  assign pop      = (count_q != '0) && (!out_valid_q || out_ready);
  assign head     = inst_mem[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  always_comb begin
    ctrl    = '0;
    rsv     = 1'b0;
    is_eret = EN_CP0 && (head == ERET_W);
    case (head[31:26])
      6'h00: case (head[5:0])
        6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
        6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: ctrl = C_RW | C_RD;
        6'h10: if (EN_MULDIV) ctrl = C_RW | C_RD | C_RET_HILO | C_HTR; else rsv = 1'b1;
        6'h12: if (EN_MULDIV) ctrl = C_RW | C_RD | C_RET_HILO; else rsv = 1'b1;
        6'h11: if (EN_MULDIV) ctrl = C_HW | C_HTR | C_HS; else rsv = 1'b1;
        6'h13: if (EN_MULDIV) ctrl = C_HW | C_HS; else rsv = 1'b1;
        6'h18, 6'h19, 6'h1A, 6'h1B: if (EN_MULDIV) ctrl = C_HW; else rsv = 1'b1;
        6'h08: ctrl = C_J | C_JS;
        6'h09: ctrl = C_RW | C_RD | C_J | C_JS | C_LNK;
        6'h0C: ctrl = C_SYS;
        6'h0D: ctrl = C_BRK;
        default: rsv = 1'b1;
      endcase
      6'h01: case (head[20:16])
        5'b00000, 5'b00001: ctrl = C_BR_Z;
        5'b10000, 5'b10001: ctrl = C_RW | C_RD | C_BR_Z | C_LNK | C_LD;
        default: rsv = 1'b1;
      endcase
      6'h02: ctrl = C_J;
      6'h03: ctrl = C_RW | C_RD | C_J | C_LNK | C_LD;
      6'h04, 6'h05, 6'h06, 6'h07: ctrl = C_BR_EQ;
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: ctrl = C_RW | C_AS;
      6'h10: begin
        // ERET shares the COP0 opcode; it is matched on the full word and carries no ctrl.
        if (!EN_CP0)                   rsv  = 1'b1;
        else if (is_eret)              ctrl = '0;
        else if (head[25:21] == 5'h00) ctrl = C_RW | C_RET_CP0;
        else if (head[25:21] == 5'h04) ctrl = C_CPW;
        else                           rsv  = 1'b1;
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: ctrl = C_RW | C_AS | C_MR;
      6'h28, 6'h29, 6'h2B: ctrl = C_AS | C_MW;
      default: rsv = 1'b1;
    endcase
    if (rsv) ctrl = C_RSV;
  end

  always_comb begin
    exc = 5'h00;
    if (ctrl[3])      exc = 5'h09;
    else if (ctrl[2]) exc = 5'h08;
    else if (ctrl[1]) exc = 5'h0A;
  end

  always_ff @(posedge clk) begin
    if (resetn && !flush && push) begin
      inst_mem[wr_ptr_q] <= in_inst;
      pc_mem[wr_ptr_q]   <= in_pc;
      ds_mem[wr_ptr_q]   <= in_ds;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_pc_q    <= '0;
      out_ds_q    <= 1'b0;
      out_ctrl_q  <= '0;
      out_eret_q  <= 1'b0;
      out_exc_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      if (pop) begin
        out_valid_q <= 1'b1;
        out_inst_q  <= head;
        out_pc_q    <= pc_mem[rd_ptr_q];
        out_ds_q    <= ds_mem[rd_ptr_q];
        out_ctrl_q  <= ctrl;
        out_eret_q  <= is_eret;
        out_exc_q   <= exc;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_pc    = out_pc_q;
  assign out_ds    = out_ds_q;
  assign out_ctrl  = out_ctrl_q;
  assign out_eret  = out_eret_q;
  assign out_exc   = out_exc_q;
  assign count     = count_q;
endmodule

// File: tb/tb_id_decode_queue.sv
// Directed bench for id_decode_queue: reset, latency, full/drain, decode table in both MULDIV modes, flush.
module tb_id_decode_queue;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, flush, in_valid, in_ds, out_ready;
  logic [31:0] in_inst, in_pc;
  logic        in_ready, out_valid, out_ds, out_eret;
  logic [31:0] out_inst, out_pc;
  logic [19:0] out_ctrl;
  logic [4:0]  out_exc;
  logic [2:0]  count;

  logic        m_in_ready, m_out_valid, m_out_ds, m_out_eret;
  logic [31:0] m_out_inst, m_out_pc;
  logic [19:0] m_out_ctrl;
  logic [4:0]  m_out_exc;
  logic [2:0]  m_count;

  int n_total = 0;
  int n_pass  = 0;

  id_decode_queue #(.DEPTH(4), .PC_W(32), .EN_MULDIV(1'b1), .EN_CP0(1'b1)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .in_ds(in_ds), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .out_ds(out_ds), .out_ctrl(out_ctrl),
    .out_eret(out_eret), .out_exc(out_exc), .count(count));

  id_decode_queue #(.DEPTH(4), .PC_W(32), .EN_MULDIV(1'b0), .EN_CP0(1'b1)) dut_nomd (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .in_ds(in_ds), .out_valid(m_out_valid), .out_ready(out_ready),
    .out_inst(m_out_inst), .out_pc(m_out_pc), .out_ds(m_out_ds), .out_ctrl(m_out_ctrl),
    .out_eret(m_out_eret), .out_exc(m_out_exc), .count(m_count));

  // inst, ctrl/exc/eret with MULDIV enabled, ctrl/exc with MULDIV disabled
  logic [31:0] vec_inst   [18] = '{32'h00851021, 32'h8C820004, 32'hAC820004, 32'h10850003,
                                   32'h04910002, 32'h0C000010, 32'h03E00008, 32'h0000000C,
                                   32'h0000000D, 32'h00001010, 32'h40026000, 32'h40826000,
                                   32'h42000018, 32'h04020000, 32'h00850018, 32'h02000011,
                                   32'h34420001, 32'h00021043};
  logic [19:0] vec_ctrl   [18] = '{20'hC0000, 20'hA2000, 20'h24000, 20'h00100,
                                   20'hC0230, 20'hC00B0, 20'h000C0, 20'h00004,
                                   20'h00008, 20'hC8800, 20'h90000, 20'h00001,
                                   20'h00000, 20'h00002, 20'h01000, 20'h01C00,
                                   20'hA0000, 20'hC0000};
  logic [4:0]  vec_exc    [18] = '{5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h08,
                                   5'h09, 5'h00, 5'h00, 5'h00, 5'h00, 5'h0A, 5'h00, 5'h00,
                                   5'h00, 5'h00};
  logic        vec_eret   [18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [19:0] vec_mctrl  [18] = '{20'hC0000, 20'hA2000, 20'h24000, 20'h00100,
                                   20'hC0230, 20'hC00B0, 20'h000C0, 20'h00004,
                                   20'h00008, 20'h00002, 20'h90000, 20'h00001,
                                   20'h00000, 20'h00002, 20'h00002, 20'h00002,
                                   20'hA0000, 20'hC0000};
  logic [4:0]  vec_mexc   [18] = '{5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h08,
                                   5'h09, 5'h0A, 5'h00, 5'h00, 5'h00, 5'h0A, 5'h0A, 5'h0A,
                                   5'h00, 5'h00};

  task automatic test_reset();
    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0;
    in_ds = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else n_pass++;
    n_total++; if (count !== 3'd0) $display("FAIL reset_count got %0d exp 0", count); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else n_pass++;
    n_total++; if (out_ctrl !== 20'h0) $display("FAIL reset_out_ctrl got %h exp 00000", out_ctrl); else n_pass++;
    n_total++; if (out_exc !== 5'h0) $display("FAIL reset_out_exc got %h exp 00", out_exc); else n_pass++;
    resetn = 1'b1;
  endtask

  task automatic test_latency();
    in_valid = 1'b1; in_inst = 32'h00851021; in_pc = 32'hBFC00000; in_ds = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_ds = 1'b0;
    n_total++; if (out_valid !== 1'b0) $display("FAIL lat_early_valid got %b exp 0", out_valid); else n_pass++;
    n_total++; if (count !== 3'd1) $display("FAIL lat_count_after_push got %0d exp 1", count); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (out_valid !== 1'b1) $display("FAIL lat_valid got %b exp 1", out_valid); else n_pass++;
    n_total++; if (out_ctrl !== 20'hC0000) $display("FAIL lat_ctrl got %h exp C0000", out_ctrl); else n_pass++;
    n_total++; if (out_exc !== 5'h00) $display("FAIL lat_exc got %h exp 00", out_exc); else n_pass++;
    n_total++; if (out_pc !== 32'hBFC00000) $display("FAIL lat_pc got %h exp BFC00000", out_pc); else n_pass++;
    n_total++; if (out_ds !== 1'b1) $display("FAIL lat_ds got %b exp 1", out_ds); else n_pass++;
    n_total++; if (out_inst !== 32'h00851021) $display("FAIL lat_inst got %h exp 00851021", out_inst); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL lat_drain_valid got %b exp 0", out_valid); else n_pass++;
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_inst = 32'h00851021; in_pc = 32'h100 + 32'(4 * i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_total++; if (count !== 3'd4) $display("FAIL full_count got %0d exp 4", count); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL full_in_ready got %b exp 0", in_ready); else n_pass++;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_total++;
      if (out_valid !== 1'b1 || out_pc !== 32'h100 + 32'(4 * k))
        $display("FAIL drain_%0d got valid=%b pc=%h exp valid=1 pc=%h", k, out_valid, out_pc, 32'h100 + 32'(4 * k));
      else n_pass++;
      @(posedge clk); #1;
    end
    n_total++; if (out_valid !== 1'b0) $display("FAIL drain_end_valid got %b exp 0", out_valid); else n_pass++;
    n_total++; if (count !== 3'd0) $display("FAIL drain_end_count got %0d exp 0", count); else n_pass++;
  endtask

  task automatic test_decode_modes();
    out_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      in_valid = 1'b1; in_inst = vec_inst[i]; in_pc = 32'h400 + 32'(i);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      n_total++;
      if (out_valid !== 1'b1 || out_ctrl !== vec_ctrl[i])
        $display("FAIL dec_ctrl_%h got valid=%b ctrl=%h exp valid=1 ctrl=%h", vec_inst[i], out_valid, out_ctrl, vec_ctrl[i]);
      else n_pass++;
      n_total++;
      if (out_exc !== vec_exc[i] || out_eret !== vec_eret[i])
        $display("FAIL dec_exc_%h got exc=%h eret=%b exp exc=%h eret=%b", vec_inst[i], out_exc, out_eret, vec_exc[i], vec_eret[i]);
      else n_pass++;
      n_total++;
      if (m_out_valid !== 1'b1 || m_out_ctrl !== vec_mctrl[i] || m_out_exc !== vec_mexc[i])
        $display("FAIL nomd_%h got valid=%b ctrl=%h exc=%h exp valid=1 ctrl=%h exc=%h",
                 vec_inst[i], m_out_valid, m_out_ctrl, m_out_exc, vec_mctrl[i], vec_mexc[i]);
      else n_pass++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_inst = 32'h34420001; in_pc = 32'h200 + 32'(4 * i);
      @(posedge clk); #1;
    end
    n_total++; if (count !== 3'd3) $display("FAIL pre_flush_count got %0d exp 3", count); else n_pass++;
    n_total++; if (out_valid !== 1'b1) $display("FAIL pre_flush_valid got %b exp 1", out_valid); else n_pass++;
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'h00851021; in_pc = 32'hDEAD0000;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    n_total++; if (count !== 3'd0) $display("FAIL flush_count got %0d exp 0", count); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL flush_valid got %b exp 0", out_valid); else n_pass++;
    n_total++; if (out_ctrl !== 20'h0 || out_pc !== 32'h0) $display("FAIL flush_regs got ctrl=%h pc=%h exp 00000/00000000", out_ctrl, out_pc); else n_pass++;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_total++;
      if (out_valid !== 1'b0 || count !== 3'd0)
        $display("FAIL flush_leak_%0d got valid=%b count=%0d pc=%h exp valid=0 count=0", k, out_valid, count, out_pc);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_full();
    test_decode_modes();
    test_flush();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
